// File: rtl/timer_peripheral.sv
// timer_peripheral: memory-mapped 32-bit reload timer with a level interrupt.
// Registers (offset from BASE_ADDR): 0x0 TH reload, 0x4 TL count,
// 0x8 TCON {status, irq_en, count_en}, 0xC SYSTICK (read-only).
// Optional feature macro: TIMER_SYSTICK_EN adds a free-running SYSTICK counter;
// without it offset 0xC reads 0 and no SYSTICK flops exist.
module timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  logic [31:0] th_reg, th_next;
  logic [31:0] tl_reg, tl_next;
  logic [2:0]  tcon_reg, tcon_next;
  logic [31:0] systick_val;

  logic        hit;
  logic [1:0]  offset;
  logic        wr_hit;
  logic        overflow;
  logic        status_set;
  logic        unused_addr_bits;

  assign hit              = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset           = addr[3:2];
  assign wr_hit           = wr & hit;
  // Byte lane bits are don't-care for word registers.
  assign unused_addr_bits = ^addr[1:0];

  // Overflow and the status set it causes are judged on the pre-write TCON,
  // so a same-edge TCON write never suppresses this edge's count or interrupt.
  assign overflow   = tcon_reg[0] && (tl_reg == 32'hFFFFFFFF);
  assign status_set = overflow & tcon_reg[1];

  // Next-state: counting first, then bus writes override (TL write beats reload,
  // TH write only affects future reloads, status set survives a clearing write).
  always_comb begin
    th_next   = th_reg;
    tl_next   = tl_reg;
    tcon_next = {tcon_reg[2] | status_set, tcon_reg[1:0]};
    if (tcon_reg[0]) begin
      tl_next = overflow ? th_reg : tl_reg + 32'd1;
    end
    if (wr_hit) begin
      case (offset)
        2'd0:    th_next   = wdata;
        2'd1:    tl_next   = wdata;
        2'd2:    tcon_next = {wdata[2] | status_set, wdata[1:0]};
        default: ;
      endcase
    end
  end

  // Register bank with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_reg   <= '0;
      tl_reg   <= '0;
      tcon_reg <= '0;
    end else begin
      th_reg   <= th_next;
      tl_reg   <= tl_next;
      tcon_reg <= tcon_next;
    end
  end

`ifdef TIMER_SYSTICK_EN
  logic [31:0] systick_reg;

  // Free-running tick counter, independent of TCON, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick_reg <= '0;
    end else begin
      systick_reg <= systick_reg + 32'd1;
    end
  end

  assign systick_val = systick_reg;
`else
  assign systick_val = 32'd0;
`endif

  // Combinational read mux; misses and idle cycles return zero.
  always_comb begin
    rdata = 32'd0;
    if (rd && hit) begin
      case (offset)
        2'd0:    rdata = th_reg;
        2'd1:    rdata = tl_reg;
        2'd2:    rdata = {29'd0, tcon_reg};
        default: rdata = systick_val;
      endcase
    end
  end

  assign irqout = tcon_reg[1] & tcon_reg[2];

endmodule
